// File: rtl/rice_core_pkg.sv
// rice_core_pkg: shared types for the rice core bus arbiter (bus source IDs, lock states, request/response structs)
package rice_core_pkg;
  localparam int RICE_CORE_XLEN = 32;
  typedef logic [RICE_CORE_XLEN-1:0] rice_core_word_t;
  typedef logic [RICE_CORE_XLEN/8-1:0] rice_core_strobe_t;
  typedef enum logic {FETCH = 1'b0, DATA = 1'b1} rice_core_bus_source;
  typedef enum logic [1:0] {LOCK_IDLE, LOCK_FETCH, LOCK_DATA} rice_core_lock_state;
  typedef struct packed {
    rice_core_word_t address;
    logic write;
    rice_core_strobe_t strobe;
    rice_core_word_t data;
  } rice_core_bus_request_t;
  typedef struct packed {
    rice_core_word_t data;
    logic error;
  } rice_core_bus_response_t;
endpackage

// File: rtl/rice_core_id_fifo.sv
// rice_core_id_fifo: small synchronous FIFO (WIDTH x DEPTH) with full/empty flags
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push/i_push_data write side;
//        i_pop/o_pop_data read side (o_pop_data shows the head); o_full/o_empty status.
module rice_core_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  assign do_push = i_push && !o_full;
  assign do_pop = i_pop && !o_empty;
  assign o_pop_data = mem[rd_ptr];
  assign o_full = count == CW'(DEPTH);
  assign o_empty = count == '0;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= i_push_data;
        wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/rice_core_bus_arbiter.sv
// rice_core_bus_arbiter: shares one bus port between fetch and data requesters with locked round-robin grant and in-order response routing
// Ports: i_clk/i_rst_n clock and async active-low reset;
//        i_fetch_request_* / o_fetch_response_* fetch requester; i_data_request_* / o_data_response_* data requester;
//        o_bus_request_* / i_bus_response_* the shared external bus port.
module rice_core_bus_arbiter
  import rice_core_pkg::*;
#(
  parameter int XLEN = RICE_CORE_XLEN,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fetch_request_valid,
  output logic              o_fetch_request_ready,
  input  logic [XLEN-1:0]   i_fetch_request_address,
  output logic              o_fetch_response_valid,
  input  logic              i_fetch_response_ready,
  output logic [XLEN-1:0]   o_fetch_response_data,
  output logic              o_fetch_response_error,
  input  logic              i_data_request_valid,
  output logic              o_data_request_ready,
  input  logic [XLEN-1:0]   i_data_request_address,
  input  logic              i_data_request_write,
  input  logic [XLEN/8-1:0] i_data_request_strobe,
  input  logic [XLEN-1:0]   i_data_request_data,
  output logic              o_data_response_valid,
  input  logic              i_data_response_ready,
  output logic [XLEN-1:0]   o_data_response_data,
  output logic              o_data_response_error,
  output logic              o_bus_request_valid,
  input  logic              i_bus_request_ready,
  output logic [XLEN-1:0]   o_bus_request_address,
  output logic              o_bus_request_write,
  output logic [XLEN/8-1:0] o_bus_request_strobe,
  output logic [XLEN-1:0]   o_bus_request_data,
  input  logic              i_bus_response_valid,
  output logic              o_bus_response_ready,
  input  logic [XLEN-1:0]   i_bus_response_data,
  input  logic              i_bus_response_error
);
  rice_core_lock_state lock_state;
  rice_core_bus_source last_grant, grant_src, head_src;
  logic grant_valid, sel_data, req_fire, rsp_fire, fifo_full, fifo_empty, fifo_head, head_data;
  always_comb begin
    grant_src = lock_state == LOCK_FETCH ? FETCH :
                lock_state == LOCK_DATA ? DATA :
                (i_fetch_request_valid && i_data_request_valid) ? (last_grant == FETCH ? DATA : FETCH) :
                i_data_request_valid ? DATA : FETCH;
    sel_data = grant_src == DATA;
    // A full FIFO only blocks fresh grants; a locked grant was issued with room, and pops only free space.
    grant_valid = lock_state == LOCK_IDLE ? !fifo_full && (i_fetch_request_valid || i_data_request_valid) :
                  sel_data ? i_data_request_valid : i_fetch_request_valid;
  end
  assign req_fire = grant_valid && i_bus_request_ready;
  assign o_bus_request_valid = grant_valid;
  assign o_bus_request_address = sel_data ? i_data_request_address : i_fetch_request_address;
  assign o_bus_request_write = sel_data && i_data_request_write;
  assign o_bus_request_strobe = sel_data ? i_data_request_strobe : '1;
  assign o_bus_request_data = sel_data ? i_data_request_data : '0;
  assign o_fetch_request_ready = grant_valid && !sel_data && i_bus_request_ready;
  assign o_data_request_ready = grant_valid && sel_data && i_bus_request_ready;
  assign head_src = rice_core_bus_source'(fifo_head);
  assign head_data = head_src == DATA;
  assign o_bus_response_ready = !fifo_empty && (head_data ? i_data_response_ready : i_fetch_response_ready);
  assign o_fetch_response_valid = !fifo_empty && !head_data && i_bus_response_valid;
  assign o_data_response_valid = !fifo_empty && head_data && i_bus_response_valid;
  assign o_fetch_response_data = i_bus_response_data;
  assign o_data_response_data = i_bus_response_data;
  assign o_fetch_response_error = i_bus_response_error;
  assign o_data_response_error = i_bus_response_error;
  assign rsp_fire = i_bus_response_valid && o_bus_response_ready;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_state <= LOCK_IDLE;
      last_grant <= DATA;
    end else if (req_fire) begin
      lock_state <= LOCK_IDLE;
      last_grant <= grant_src;
    end else if (lock_state == LOCK_IDLE && grant_valid) begin
      lock_state <= sel_data ? LOCK_DATA : LOCK_FETCH;
    end
  end
  rice_core_id_fifo #(.WIDTH(1), .DEPTH(MAX_OUTSTANDING)) u_id_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (req_fire),
    .i_push_data (grant_src == DATA),
    .i_pop       (rsp_fire),
    .o_pop_data  (fifo_head),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty)
  );
  a_fetch_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    lock_state == LOCK_FETCH |-> i_fetch_request_valid);
  a_data_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    lock_state == LOCK_DATA |-> i_data_request_valid);
  a_no_orphan_response: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(fifo_empty && i_bus_response_valid));
endmodule

// File: tb/tb_rice_core_bus_arbiter.sv
// tb_rice_core_bus_arbiter: directed self-checking bench for rice_core_bus_arbiter
module tb_rice_core_bus_arbiter;
  logic clk = 1'b0, rst_n;
  logic fv, f_rdy, f_rsp_v, f_rsp_rdy, f_rsp_e;
  logic [31:0] f_addr, f_rsp_d;
  logic dv, d_rdy, d_wr, d_rsp_v, d_rsp_rdy, d_rsp_e;
  logic [31:0] d_addr, d_data, d_rsp_d;
  logic [3:0] d_strb, b_strb;
  logic b_v, b_rdy, b_wr, b_rsp_v, b_rsp_rdy, b_rsp_e;
  logic [31:0] b_addr, b_data, b_rsp_d;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;

  rice_core_bus_arbiter #(.XLEN(32), .MAX_OUTSTANDING(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fetch_request_valid(fv), .o_fetch_request_ready(f_rdy), .i_fetch_request_address(f_addr),
    .o_fetch_response_valid(f_rsp_v), .i_fetch_response_ready(f_rsp_rdy),
    .o_fetch_response_data(f_rsp_d), .o_fetch_response_error(f_rsp_e),
    .i_data_request_valid(dv), .o_data_request_ready(d_rdy), .i_data_request_address(d_addr),
    .i_data_request_write(d_wr), .i_data_request_strobe(d_strb), .i_data_request_data(d_data),
    .o_data_response_valid(d_rsp_v), .i_data_response_ready(d_rsp_rdy),
    .o_data_response_data(d_rsp_d), .o_data_response_error(d_rsp_e),
    .o_bus_request_valid(b_v), .i_bus_request_ready(b_rdy), .o_bus_request_address(b_addr),
    .o_bus_request_write(b_wr), .o_bus_request_strobe(b_strb), .o_bus_request_data(b_data),
    .i_bus_response_valid(b_rsp_v), .o_bus_response_ready(b_rsp_rdy),
    .i_bus_response_data(b_rsp_d), .i_bus_response_error(b_rsp_e)
  );

  task automatic clear_inputs();
    fv = 0; f_addr = 32'h0000_0100; f_rsp_rdy = 0;
    dv = 0; d_addr = 0; d_wr = 0; d_strb = 0; d_data = 0; d_rsp_rdy = 0;
    b_rdy = 0; b_rsp_v = 0; b_rsp_d = 0; b_rsp_e = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0; clear_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (b_v !== 1'b0) begin errors++; $display("FAIL reset_bus_valid: got %b want 0", b_v); end
    checks++; if (f_rsp_v !== 1'b0 || d_rsp_v !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b%b want 00", f_rsp_v, d_rsp_v); end
    checks++; if (b_rsp_rdy !== 1'b0) begin errors++; $display("FAIL reset_bus_rsp_ready: got %b want 0", b_rsp_rdy); end
    checks++; if (f_rdy !== 1'b0 || d_rdy !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b%b want 00", f_rdy, d_rdy); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_fetch_only();
    clear_inputs(); fv = 1; f_addr = 32'h0000_0100; b_rdy = 1;
    #1;
    checks++; if (b_v !== 1'b1 || b_addr !== 32'h0000_0100) begin errors++; $display("FAIL fetch_req: got v=%b a=%h want v=1 a=00000100", b_v, b_addr); end
    checks++; if (b_wr !== 1'b0 || b_strb !== 4'hF || b_data !== 32'h0) begin errors++; $display("FAIL fetch_req_fields: got w=%b s=%h d=%h want w=0 s=f d=0", b_wr, b_strb, b_data); end
    checks++; if (f_rdy !== 1'b1 || d_rdy !== 1'b0) begin errors++; $display("FAIL fetch_ready: got f=%b d=%b want f=1 d=0", f_rdy, d_rdy); end
    @(negedge clk);
    clear_inputs(); b_rsp_v = 1; b_rsp_d = 32'h0000_0013; f_rsp_rdy = 1;
    #1;
    checks++; if (f_rsp_v !== 1'b1 || f_rsp_d !== 32'h13) begin errors++; $display("FAIL fetch_rsp: got v=%b d=%h want v=1 d=00000013", f_rsp_v, f_rsp_d); end
    checks++; if (d_rsp_v !== 1'b0 || b_rsp_rdy !== 1'b1) begin errors++; $display("FAIL fetch_rsp_route: got dv=%b rdy=%b want dv=0 rdy=1", d_rsp_v, b_rsp_rdy); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_alternate();
    logic exp_f;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      clear_inputs(); fv = 1; dv = 1; f_addr = 32'h100; d_addr = 32'h200; b_rdy = 1;
      f_rsp_rdy = 1; d_rsp_rdy = 1; b_rsp_v = i > 0; b_rsp_d = i;
      exp_f = i % 2 == 0;
      #1;
      checks++; if (f_rdy !== exp_f || d_rdy !== !exp_f) begin errors++; $display("FAIL alt_grant[%0d]: got f=%b d=%b want f=%b", i, f_rdy, d_rdy, exp_f); end
      checks++; if (b_addr !== (exp_f ? 32'h100 : 32'h200)) begin errors++; $display("FAIL alt_addr[%0d]: got %h want %h", i, b_addr, exp_f ? 32'h100 : 32'h200); end
      if (i > 0) begin
        checks++; if (f_rsp_v !== !exp_f || d_rsp_v !== exp_f) begin errors++; $display("FAIL alt_rsp[%0d]: got f=%b d=%b want f=%b d=%b", i, f_rsp_v, d_rsp_v, !exp_f, exp_f); end
      end
      @(negedge clk);
    end
    clear_inputs(); b_rsp_v = 1; b_rsp_d = 32'h33; f_rsp_rdy = 1; d_rsp_rdy = 1;
    #1;
    checks++; if (d_rsp_v !== 1'b1 || f_rsp_v !== 1'b0 || b_v !== 1'b0) begin errors++; $display("FAIL alt_drain: got d=%b f=%b bv=%b want d=1 f=0 bv=0", d_rsp_v, f_rsp_v, b_v); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_lock();
    for (int c = 0; c < 4; c++) begin
      clear_inputs(); dv = 1; d_wr = 1; d_addr = 32'h8000_0000; d_data = 32'hDEAD_BEEF; d_strb = 4'hF;
      fv = c > 0; b_rdy = c == 3;
      #1;
      checks++; if (b_v !== 1'b1 || b_addr !== 32'h8000_0000 || b_wr !== 1'b1 || b_data !== 32'hDEAD_BEEF || b_strb !== 4'hF)
        begin errors++; $display("FAIL lock_bus[%0d]: got v=%b a=%h w=%b d=%h s=%h want 1 80000000 1 deadbeef f", c, b_v, b_addr, b_wr, b_data, b_strb); end
      checks++; if (f_rdy !== 1'b0 || d_rdy !== (c == 3)) begin errors++; $display("FAIL lock_ready[%0d]: got f=%b d=%b want f=0 d=%b", c, f_rdy, d_rdy, c == 3); end
      @(negedge clk);
    end
    clear_inputs(); fv = 1; b_rdy = 1;
    #1;
    checks++; if (b_addr !== 32'h100 || f_rdy !== 1'b1) begin errors++; $display("FAIL lock_fetch_after: got a=%h f=%b want a=00000100 f=1", b_addr, f_rdy); end
    @(negedge clk);
    clear_inputs(); fv = 1; b_rdy = 1; b_rsp_v = 1; b_rsp_d = 32'hAA; f_rsp_rdy = 1; d_rsp_rdy = 1;
    #1;
    checks++; if (b_v !== 1'b0 || f_rdy !== 1'b0) begin errors++; $display("FAIL lock_full_pop: got bv=%b f=%b want 0 0", b_v, f_rdy); end
    checks++; if (d_rsp_v !== 1'b1 || f_rsp_v !== 1'b0 || d_rsp_d !== 32'hAA) begin errors++; $display("FAIL lock_rsp_data: got d=%b f=%b dd=%h want 1 0 aa", d_rsp_v, f_rsp_v, d_rsp_d); end
    @(negedge clk);
    clear_inputs(); b_rsp_v = 1; b_rsp_d = 32'hBB; f_rsp_rdy = 1; d_rsp_rdy = 1;
    #1;
    checks++; if (f_rsp_v !== 1'b1 || d_rsp_v !== 1'b0 || f_rsp_d !== 32'hBB) begin errors++; $display("FAIL lock_rsp_fetch: got f=%b d=%b fd=%h want 1 0 bb", f_rsp_v, d_rsp_v, f_rsp_d); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_full();
    clear_inputs(); fv = 1; b_rdy = 1;
    #1;
    checks++; if (f_rdy !== 1'b1) begin errors++; $display("FAIL full_first: got f=%b want 1", f_rdy); end
    @(negedge clk);
    clear_inputs(); dv = 1; d_addr = 32'h300; b_rdy = 1;
    #1;
    checks++; if (d_rdy !== 1'b1 || b_addr !== 32'h300) begin errors++; $display("FAIL full_second: got d=%b a=%h want 1 00000300", d_rdy, b_addr); end
    @(negedge clk);
    clear_inputs(); fv = 1; b_rdy = 1;
    #1;
    checks++; if (b_v !== 1'b0 || f_rdy !== 1'b0) begin errors++; $display("FAIL full_block: got bv=%b f=%b want 0 0", b_v, f_rdy); end
    @(negedge clk);
    clear_inputs(); b_rsp_v = 1; b_rsp_d = 32'h11; f_rsp_rdy = 1; d_rsp_rdy = 1;
    #1;
    checks++; if (f_rsp_v !== 1'b1 || d_rsp_v !== 1'b0 || f_rsp_d !== 32'h11) begin errors++; $display("FAIL full_rsp1: got f=%b d=%b fd=%h want 1 0 11", f_rsp_v, d_rsp_v, f_rsp_d); end
    @(negedge clk);
    b_rsp_d = 32'h22;
    #1;
    checks++; if (d_rsp_v !== 1'b1 || f_rsp_v !== 1'b0 || d_rsp_d !== 32'h22) begin errors++; $display("FAIL full_rsp2: got d=%b f=%b dd=%h want 1 0 22", d_rsp_v, f_rsp_v, d_rsp_d); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_error();
    clear_inputs(); dv = 1; d_addr = 32'h400; b_rdy = 1;
    #1;
    checks++; if (d_rdy !== 1'b1) begin errors++; $display("FAIL err_req: got d=%b want 1", d_rdy); end
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      clear_inputs(); b_rsp_v = 1; b_rsp_d = 32'h55; b_rsp_e = 1; d_rsp_rdy = c == 2; f_rsp_rdy = 1;
      #1;
      checks++; if (d_rsp_v !== 1'b1 || d_rsp_e !== 1'b1 || f_rsp_v !== 1'b0) begin errors++; $display("FAIL err_rsp[%0d]: got dv=%b de=%b fv=%b want 1 1 0", c, d_rsp_v, d_rsp_e, f_rsp_v); end
      checks++; if (b_rsp_rdy !== (c == 2)) begin errors++; $display("FAIL err_ready[%0d]: got %b want %b", c, b_rsp_rdy, c == 2); end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    clear_inputs(); fv = 1; b_rdy = 1;
    @(negedge clk);
    clear_inputs(); dv = 1; b_rdy = 1;
    @(negedge clk);
    clear_inputs(); rst_n = 0; b_rsp_v = 1; f_rsp_rdy = 1; d_rsp_rdy = 1;
    #1;
    checks++; if (b_rsp_rdy !== 1'b0 || f_rsp_v !== 1'b0 || d_rsp_v !== 1'b0) begin errors++; $display("FAIL rstmid_in_reset: got rdy=%b f=%b d=%b want 000", b_rsp_rdy, f_rsp_v, d_rsp_v); end
    b_rsp_v = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    b_rsp_v = 1;
    #1;
    checks++; if (b_rsp_rdy !== 1'b0 || f_rsp_v !== 1'b0 || d_rsp_v !== 1'b0) begin errors++; $display("FAIL rstmid_spurious: got rdy=%b f=%b d=%b want 000", b_rsp_rdy, f_rsp_v, d_rsp_v); end
    b_rsp_v = 0;
    @(negedge clk);
    clear_inputs(); fv = 1; dv = 1; b_rdy = 1;
    #1;
    checks++; if (f_rdy !== 1'b1 || d_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_regrant: got f=%b d=%b want 1 0", f_rdy, d_rdy); end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_alternate();
    test_lock();
    test_full();
    test_error();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rice_core_bus_arbiter.md
Name: rice_core_bus_arbiter

Overview:
- Shares one memory bus port between the instruction-fetch requester and the load/store (data) requester of the rice core.
- Request side: round-robin arbitration with a grant lock that holds until the granted request handshakes.
- Response side: in-order routing back to the originating requester, using a FIFO of source IDs for outstanding transactions.
- Sits between the fetch/memory-access stages and the core's external bus interface.

Parameters:
- XLEN, 32, address/data width.
- MAX_OUTSTANDING, 2, number of accepted-but-unanswered bus requests allowed (>=1).

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_fetch_request_valid  input  1  fetch request valid
- o_fetch_request_ready  output  1  fetch request accepted
- i_fetch_request_address  input  XLEN  fetch address
- o_fetch_response_valid  output  1  fetch response valid
- i_fetch_response_ready  input  1  fetch response taken
- o_fetch_response_data  output  XLEN  fetched instruction word
- o_fetch_response_error  output  1  bus error for fetch
- i_data_request_valid  input  1  data request valid
- o_data_request_ready  output  1  data request accepted
- i_data_request_address  input  XLEN  data address
- i_data_request_write  input  1  1=store, 0=load
- i_data_request_strobe  input  XLEN/8  byte enables
- i_data_request_data  input  XLEN  store data
- o_data_response_valid  output  1  data response valid
- i_data_response_ready  input  1  data response taken
- o_data_response_data  output  XLEN  load data
- o_data_response_error  output  1  bus error for data
- o_bus_request_valid / i_bus_request_ready  output/input  1  bus request handshake
- o_bus_request_address  output  XLEN
- o_bus_request_write  output  1
- o_bus_request_strobe  output  XLEN/8  (all ones for fetch)
- o_bus_request_data  output  XLEN  (zero for fetch)
- i_bus_response_valid / o_bus_response_ready  input/output  1  bus response handshake
- i_bus_response_data  input  XLEN
- i_bus_response_error  input  1

Behaviour:
- Clock i_clk; reset i_rst_n is asynchronous, active-low. All registers are cleared on reset.
- Reset values: all valid/ready outputs 0; lock state IDLE; FIFO empty; last_grant=DATA (so fetch wins the first tie).
- Grant state machine:
  - IDLE: if the FIFO is full, no grant and o_bus_request_valid=0. Otherwise, one requester valid → grant it; both valid → grant the one not equal to last_grant.
  - A grant issued in IDLE without i_bus_request_ready moves to LOCK_FETCH or LOCK_DATA.
  - LOCK_x: drive requester x only, ignoring the other requester. On bus handshake, return to IDLE.
  - The requester must hold valid and payload stable until ready; a drop of valid while locked is flagged by an assertion.
- Request path is zero-latency combinational mux. Ready of the granted requester = i_bus_request_ready; ready of the other requester = 0.
- On request handshake:
  - push source ID (0=fetch, 1=data) into the FIFO;
  - last_grant <= source.
- FIFO full blocks new requests even if a pop occurs in the same cycle; there is no combinational path from response to request.
- Response path:
  - FIFO head selects the destination.
  - Destination valid = i_bus_response_valid; o_bus_response_ready = destination ready.
  - Data and error pass through to both requesters; only the selected valid is asserted.
  - Pop on response handshake.
- FIFO empty with i_bus_response_valid=1 is a protocol violation: o_bus_response_ready=0, both response valids 0, assertion fires.
- Same-cycle push and pop is allowed (count unchanged). FIFO pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-transaction discards all outstanding IDs; no responses are delivered after reset.

Decomposition:
- Add to rice_core_pkg:
  - rice_core_bus_source enum (FETCH=0, DATA=1);
  - bus request/response packed structs (address, write, strobe, data / data, error), parameterised by XLEN-sized typedefs.
- Sub-module rice_core_id_fifo: generic synchronous FIFO (WIDTH, DEPTH) holding source IDs, with full/empty outputs.

Test Plan:
- Fetch only, addr 0x0000_0100, bus ready immediately, response data 0x0000_0013 next cycle → fetch response valid with 0x13; data side stays idle.
- Both valid in the cycle after reset → fetch granted first, then data. Repeated simultaneous requests alternate F,D,F,D.
- Data store (addr 0x8000_0000, data 0xDEAD_BEEF, strobe 0xF) with bus ready held 0 for 3 cycles while fetch asserts valid → grant stays on data; fetch ready 0 throughout; fetch is issued after the store handshake.
- MAX_OUTSTANDING=2: fetch then data accepted with no responses → third request blocked (bus valid 0). Responses 0x11 then 0x22 → 0x11 routed to fetch, 0x22 to data, in order.
- Response with i_bus_response_error=1 for a load, with i_data_response_ready=0 for 2 cycles → o_bus_response_ready=0 until taken; error=1 is delivered on the data port.
- Assert i_rst_n=0 with 2 outstanding → FIFO empty, all valids 0; a spurious bus response afterwards gets ready=0 and fires the assertion.
